// File: rtl/hamming_ecc_sequencer.sv
// Feeds words one at a time through the combinational Hamming encode/inject/decode
// datapath, captures the decoded result after a fixed settle time and keeps ECC statistics.
module hamming_ecc_sequencer #(
    parameter int DATA_W        = 32,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              cfg_inject_en,
    input  logic [7:0]        cfg_inject_period,
    output logic [DATA_W-1:0] hc_data,
    output logic              hc_inject_error,
    input  logic [DATA_W-1:0] hc_dec_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_injected,
    output logic              out_mismatch,
    output logic [CNT_W-1:0]  word_count,
    output logic [CNT_W-1:0]  mismatch_count
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_hc_data;
    logic                r_hc_inject;
    logic [DATA_W-1:0]   r_ref_data;
    logic [SW-1:0]       r_settle;
    logic [7:0]          r_inj_ctr;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_injected;
    logic                r_out_mismatch;
    logic [CNT_W-1:0]    r_word_count;
    logic [CNT_W-1:0]    r_mismatch_count;

    logic                w_inj_active;
    logic [7:0]          w_period_m1;
    logic                w_inject;

    // ">=" rather than "==" so a period shortened below the running count fires at once
    assign w_inj_active = cfg_inject_en && (cfg_inject_period != 8'd0);
    assign w_period_m1  = cfg_inject_period - 8'd1;
    assign w_inject     = w_inj_active && (r_inj_ctr >= w_period_m1);

    assign in_ready        = (r_state == IDLE);
    assign hc_data         = r_hc_data;
    assign hc_inject_error = r_hc_inject;
    assign out_valid       = r_out_valid;
    assign out_data        = r_out_data;
    assign out_injected    = r_out_injected;
    assign out_mismatch    = r_out_mismatch;
    assign word_count      = r_word_count;
    assign mismatch_count  = r_mismatch_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_hc_data        <= '0;
            r_hc_inject      <= 1'b0;
            r_ref_data       <= '0;
            r_settle         <= '0;
            r_inj_ctr        <= 8'd0;
            r_out_valid      <= 1'b0;
            r_out_data       <= '0;
            r_out_injected   <= 1'b0;
            r_out_mismatch   <= 1'b0;
            r_word_count     <= '0;
            r_mismatch_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_hc_data   <= in_data;
                        r_ref_data  <= in_data;
                        r_hc_inject <= w_inject;
                        r_settle    <= '0;
                        if (w_inject) begin
                            r_inj_ctr <= 8'd0;
                        end else if (w_inj_active) begin
                            r_inj_ctr <= r_inj_ctr + 8'd1;
                        end
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    r_settle <= r_settle + 1'b1;
                    if (r_settle == SETTLE_LAST) begin
                        r_out_data     <= hc_dec_data;
                        r_out_mismatch <= (hc_dec_data != r_ref_data);
                        r_out_injected <= r_hc_inject;
                        r_out_valid    <= 1'b1;
                        r_state        <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_hc_inject <= 1'b0;
                        r_state     <= IDLE;
                        if (r_word_count != {CNT_W{1'b1}}) begin
                            r_word_count <= r_word_count + 1'b1;
                        end
                        if (r_out_mismatch && (r_mismatch_count != {CNT_W{1'b1}})) begin
                            r_mismatch_count <= r_mismatch_count + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_ecc_sequencer.sv
// Scoreboard bench for hamming_ecc_sequencer: directed words, a behavioural datapath
// with an optional stuck-bit fault, and a monitor that checks each delivered result.
module tb_hamming_ecc_sequencer;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              cfg_inject_en = 1'b0;
    logic [7:0]        cfg_inject_period = 8'd0;
    logic [DATA_W-1:0] hc_data;
    logic              hc_inject_error;
    logic [DATA_W-1:0] hc_dec_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              out_injected;
    logic              out_mismatch;
    logic [CNT_W-1:0]  word_count;
    logic [CNT_W-1:0]  mismatch_count;

    logic fault = 1'b0;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              inj;
        logic              mm;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // Healthy SEC datapath returns the word; the faulty one leaves bit 0 flipped
    assign hc_dec_data = (fault && hc_inject_error) ? (hc_data ^ 32'h1) : hc_data;

    hamming_ecc_sequencer #(
        .DATA_W(DATA_W),
        .SETTLE_CYCLES(2),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .cfg_inject_en(cfg_inject_en),
        .cfg_inject_period(cfg_inject_period),
        .hc_data(hc_data),
        .hc_inject_error(hc_inject_error),
        .hc_dec_data(hc_dec_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_injected(out_injected),
        .out_mismatch(out_mismatch),
        .word_count(word_count),
        .mismatch_count(mismatch_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: samples just after the falling edge, when bench inputs have settled
    initial begin : monitor
        logic              prev_hold;
        logic [DATA_W-1:0] prev_d;
        logic              prev_inj;
        logic              prev_mm;
        exp_t              e;
        prev_hold = 1'b0;
        prev_d    = '0;
        prev_inj  = 1'b0;
        prev_mm   = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (out_valid && prev_hold) begin
                    check("hold_data", out_data, prev_d);
                    check("hold_flags", {30'd0, out_injected, out_mismatch}, {30'd0, prev_inj, prev_mm});
                end
                if (out_valid && out_ready) begin
                    $display("result data=%h injected=%0b mismatch=%0b", out_data, out_injected, out_mismatch);
                    n_cmp++;
                    if (sb_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_result: got data %h expected none", out_data);
                    end else begin
                        e = sb_q.pop_front();
                        n_cmp--;
                        check("out_data", out_data, e.d);
                        check("out_injected", {31'd0, out_injected}, {31'd0, e.inj});
                        check("out_mismatch", {31'd0, out_mismatch}, {31'd0, e.mm});
                    end
                    prev_hold = 1'b0;
                end else begin
                    prev_hold = out_valid;
                end
                prev_d   = out_data;
                prev_inj = out_injected;
                prev_mm  = out_mismatch;
            end
        end
    end

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_hc", {hc_data[30:0], hc_inject_error}, 32'd0);
        check("rst_counts", {24'd0, word_count, mismatch_count}, 32'd0);
    endtask

    // Present a word and push its expectation at the accepting edge
    task automatic send(input logic [31:0] d, input logic [31:0] exp_d, input logic inj, input logic mm);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", {31'd0, in_ready}, 32'd1);
        e.d = exp_d;
        e.inj = inj;
        e.mm = mm;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin : stim
        int n;
        // 1: basic latency
        do_reset();
        send(32'd4, 32'd4, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_ov_e0", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("t1_ov_e1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("t1_ov_e2", {31'd0, out_valid}, 32'd1);
        check("t1_rdy_e2", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("t1_rdy_e3", {31'd0, in_ready}, 32'd1);
        check("t1_wc", {28'd0, word_count}, 32'd1);

        // 2: period-2 injection on a healthy datapath
        do_reset();
        cfg_inject_en = 1'b1;
        cfg_inject_period = 8'd2;
        for (int i = 0; i < 4; i++) begin
            send(32'd8456, 32'd8456, (i % 2) == 1, 1'b0);
            wait_idle();
        end
        check("t2_wc", {28'd0, word_count}, 32'd4);
        check("t2_mc", {28'd0, mismatch_count}, 32'd0);

        // 3: backpressure with a second word waiting
        do_reset();
        cfg_inject_en = 1'b0;
        out_ready = 1'b0;
        send(32'hA5A5_0001, 32'hA5A5_0001, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t3_ov_wait", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b1;
        in_data  = 32'h5A5A_0002;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_rdy_blocked", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_rdy_after_hs", {31'd0, in_ready}, 32'd1);
        check("t3_hc_before", hc_data, 32'hA5A5_0001);
        sb_q.push_back('{d: 32'h5A5A_0002, inj: 1'b0, mm: 1'b0});
        @(negedge clk);
        in_valid = 1'b0;
        check("t3_rdy_accepted", {31'd0, in_ready}, 32'd0);
        check("t3_hc_after", hc_data, 32'h5A5A_0002);
        wait_idle();
        check("t3_wc", {28'd0, word_count}, 32'd2);

        // 4: faulty datapath, inject every word
        do_reset();
        fault = 1'b1;
        cfg_inject_en = 1'b1;
        cfg_inject_period = 8'd1;
        send(32'h1234_5678, 32'h1234_5679, 1'b1, 1'b1);
        wait_idle();
        check("t4_wc1", {24'd0, word_count, mismatch_count}, {24'd0, 4'd1, 4'd1});
        send(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b1);
        wait_idle();
        send(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1);
        wait_idle();
        check("t4_wc3", {24'd0, word_count, mismatch_count}, {24'd0, 4'd3, 4'd3});
        fault = 1'b0;

        // 5: reset during SETTLE drops the in-flight word
        do_reset();
        cfg_inject_en = 1'b0;
        send(32'h0000_0011, 32'h0000_0011, 1'b0, 1'b0);
        wait_idle();
        check("t5_wc_pre", {28'd0, word_count}, 32'd1);
        send(32'h0000_0022, 32'h0000_0022, 1'b0, 1'b0);
        void'(sb_q.pop_back());
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rdy", {31'd0, in_ready}, 32'd1);
        check("t5_counts", {24'd0, word_count, mismatch_count}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_out", {31'd0, out_valid}, 32'd0);
        end
        send(32'h0000_0033, 32'h0000_0033, 1'b0, 1'b0);
        wait_idle();
        check("t5_wc_post", {28'd0, word_count}, 32'd1);

        // 6: period 0 never injects; counter saturates
        do_reset();
        cfg_inject_en = 1'b1;
        cfg_inject_period = 8'd0;
        for (int i = 0; i < 17; i++) begin
            send(32'(i * 3 + 7), 32'(i * 3 + 7), 1'b0, 1'b0);
            wait_idle();
            if (i == 14) check("t6_wc15", {28'd0, word_count}, 32'd15);
        end
        check("t6_wc_sat", {28'd0, word_count}, 32'd15);
        check("t6_mc", {28'd0, mismatch_count}, 32'd0);

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hamming_ecc_sequencer.md
Name: hamming_ecc_sequencer

Overview:
Sequences 32-bit words through the combinational Hamming encode/inject/decode datapath (top_level_module) one at a time. Accepts words from a requester over valid/ready and drives the datapath's data and inject_error inputs. Waits a fixed settle time, then captures dec_data and returns it with status flags over valid/ready. Schedules periodic error injection and keeps saturating word and mismatch statistics for ECC self-test.

Parameters:
DATA_W, 32, data word width; matches datapath data/dec_data
SETTLE_CYCLES, 2, cycles the datapath inputs are held before dec_data is captured; legal range >= 1
CNT_W, 16, width of the statistics counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  requester has a word
in_ready  output  1  sequencer can accept; high only in IDLE
in_data  input  DATA_W  word to process
cfg_inject_en  input  1  enable periodic error injection
cfg_inject_period  input  8  inject on every Nth accepted word; 0 = never
hc_data  output  DATA_W  to datapath data input (registered)
hc_inject_error  output  1  to datapath inject_error (registered)
hc_dec_data  input  DATA_W  from datapath dec_data
out_valid  output  1  result available
out_ready  input  1  consumer takes result
out_data  output  DATA_W  captured decoded word
out_injected  output  1  error was injected for this word
out_mismatch  output  1  out_data != originally accepted word
word_count  output  CNT_W  results delivered, saturating
mismatch_count  output  CNT_W  results delivered with out_mismatch=1, saturating

Behaviour:
- Clocking and reset: single clock. The synchronous active-high reset is sampled at the rising clk edge.
- Reset values: state=IDLE, hc_data=0, hc_inject_error=0, out_valid=0, out_data=0, out_injected=0, out_mismatch=0, both counters=0, internal inject counter=0, settle counter=0.
- in_ready = (state==IDLE), combinational from state.
- FSM states: IDLE, SETTLE, OUT.
- IDLE:
  - On an edge with in_valid&&in_ready: hc_data<=in_data, and in_data is also latched internally as the reference word.
  - Inject decision at the same edge: inject = cfg_inject_en && period!=0 && inj_ctr==period-1.
  - If inject, inj_ctr<=0; else if cfg_inject_en && period!=0, inj_ctr<=inj_ctr+1.
  - hc_inject_error<=inject; settle counter<=0; go to SETTLE.
  - cfg_* inputs are sampled only at acceptance.
- SETTLE:
  - Each edge increments the settle counter.
  - On the edge where the counter equals SETTLE_CYCLES-1:
    - out_data<=hc_dec_data
    - out_mismatch<=(hc_dec_data != reference word)
    - out_injected<=hc_inject_error
    - out_valid<=1; go to OUT
  - hc_data and hc_inject_error are stable throughout SETTLE.
- OUT:
  - out_* held stable while out_ready=0.
  - On an edge with out_valid&&out_ready: out_valid<=0, hc_inject_error<=0, go to IDLE.
  - At that same edge: word_count+=1 and, if out_mismatch, mismatch_count+=1. Both saturate at all-ones (no wrap).
  - hc_data retains its last value.
- Latency: acceptance at edge k gives out_valid high immediately after edge k+SETTLE_CYCLES.
  - Minimum period with out_ready=1 is SETTLE_CYCLES+2 cycles per word (next acceptance at edge k+SETTLE_CYCLES+2).
- A single injected error is corrected by the SEC datapath, so out_mismatch=1 indicates a datapath fault or an uncorrectable pattern.
- No overlap: a second word is never accepted while one is in flight.
- Reset asserted in any state takes effect at that edge: the in-flight word is dropped, no output is produced, and statistics and inj_ctr clear.
- cfg_inject_period changed mid-sequence: new value applies at the next acceptance. If inj_ctr >= new period-1, injection occurs at that acceptance and inj_ctr restarts at 0.

Test Plan:
1. Reset, inject off, out_ready=1, send in_data=4 at edge 0 -> out_valid high after edge 2; out_data=4, out_mismatch=0, out_injected=0; word_count=1 after edge 3; in_ready high again after edge 3.
2. cfg_inject_en=1, period=2, send 8456 four times -> out_injected sequence 0,1,0,1; out_data=8456 each; mismatch_count=0, word_count=4.
3. Backpressure: out_ready=0 for 5 cycles after out_valid, in_valid held high with a second word -> out_data/flags stable, in_ready=0, second word accepted only one edge after the out handshake.
4. Faulty datapath model (bench drives hc_dec_data=hc_data^32'h1 when hc_inject_error=1), period=1 -> every result out_mismatch=1, out_injected=1; mismatch_count tracks word_count.
5. Reset pulsed for one cycle during SETTLE -> out_valid stays 0 for that word, in_ready=1 next cycle, counters=0, next word processed normally.
6. cfg_inject_en=1 with period=0, and CNT_W=4 with 17 words -> out_injected never set; word_count saturates at 15.
